// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the requester ports and the memory port.
// The master drives the request; the slave accepts it and returns the response.
interface mem_arbiter_if #(
    parameter int unsigned p_addr_bits = 32,
    parameter int unsigned p_data_bits = 32
) ();
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_type;
    logic [p_addr_bits-1:0] req_addr;
    logic [p_data_bits-1:0] req_wdata;
    logic                   resp_val;
    logic [p_data_bits-1:0] resp_rdata;

    modport master (
        output req_val, req_type, req_addr, req_wdata,
        input  req_rdy, resp_val, resp_rdata
    );

    modport slave (
        input  req_val, req_type, req_addr, req_wdata,
        output req_rdy, resp_val, resp_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, with at
// most one transaction outstanding and the response routed back to its owner.
module mem_arbiter #(
    parameter int unsigned p_addr_bits = 32,
    parameter int unsigned p_data_bits = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   req0,
    mem_arbiter_if.slave   req1,
    mem_arbiter_if.master  mem
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic                   any_val;
    logic                   grant;
    logic                   grant_type;
    logic [p_addr_bits-1:0] grant_addr;
    logic [p_data_bits-1:0] grant_wdata;

    assign any_val = req0.req_val | req1.req_val;
    // A tie goes to whoever was not granted last; otherwise the sole asker wins.
    assign grant = (req0.req_val & req1.req_val) ? ~last_q : req1.req_val;

    always_comb begin
        grant_type  = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        if (any_val) begin
            if (grant) begin
                grant_type  = req1.req_type;
                grant_addr  = req1.req_addr;
                grant_wdata = req1.req_wdata;
            end else begin
                grant_type  = req0.req_type;
                grant_addr  = req0.req_addr;
                grant_wdata = req0.req_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (any_val && mem.req_rdy) begin
                    state_d = StBusy;
                    owner_d = grant;
                    last_d  = grant;
                end
            end
            StBusy: begin
                if (mem.resp_val) state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem.req_val     = 1'b0;
        mem.req_type    = 1'b0;
        mem.req_addr    = '0;
        mem.req_wdata   = '0;
        req0.req_rdy    = 1'b0;
        req1.req_rdy    = 1'b0;
        req0.resp_val   = 1'b0;
        req0.resp_rdata = '0;
        req1.resp_val   = 1'b0;
        req1.resp_rdata = '0;
        unique case (state_q)
            StIdle: begin
                mem.req_val   = any_val;
                mem.req_type  = grant_type;
                mem.req_addr  = grant_addr;
                mem.req_wdata = grant_wdata;
                req0.req_rdy  = mem.req_rdy & req0.req_val & ~grant;
                req1.req_rdy  = mem.req_rdy & req1.req_val & grant;
            end
            StBusy: begin
                // A response seen while idle is spurious and never reaches this path.
                if (mem.resp_val) begin
                    if (owner_q) begin
                        req1.resp_val   = 1'b1;
                        req1.resp_rdata = mem.resp_rdata;
                    end else begin
                        req0.resp_val   = 1'b1;
                        req0.resp_rdata = mem.resp_rdata;
                    end
                end
            end
        endcase
    end

endmodule
